morse_char_transmitter: RTL and testbench

//  Encodes one ASCII character per valid/ready handshake into an on/off Morse

---
 rtl/morse_char_transmitter_if.sv | 24 ++
 rtl/morse_char_transmitter.sv | 223 ++++++++++++++++++++++
 tb/tb_morse_char_transmitter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/morse_char_transmitter_if.sv
// Character handshake and Morse line bundle for morse_char_transmitter.
// The character source uses the master modport; the transmitter uses slave.
interface morse_char_transmitter_if #(
    parameter int DOT_PERIOD_W = 16
);
    logic [7:0]              tx_char;
    logic                    char_valid;
    logic                    char_ready;
    logic [DOT_PERIOD_W-1:0] dot_period;
    logic                    morse;
    logic                    busy;
    logic                    unknown;
    logic                    dot_period_error;

    modport master (
        output tx_char, char_valid, dot_period,
        input  char_ready, morse, busy, unknown, dot_period_error
    );

    modport slave (
        input  tx_char, char_valid, dot_period,
        output char_ready, morse, busy, unknown, dot_period_error
    );
endinterface

// File: rtl/morse_char_transmitter.sv
// Encodes one ASCII character per handshake into a registered Morse waveform.
// Define MORSE_TX_DIGITS_EN to add '0'-'9' (5-element codes); otherwise digits are unknown.
module morse_char_transmitter #(
    parameter int DOT_PERIOD_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    morse_char_transmitter_if.slave bus
);
`ifdef MORSE_TX_DIGITS_EN
    localparam int ELEM_W = 5;
`else
    localparam int ELEM_W = 4;
`endif
    localparam int IDX_W = $clog2(ELEM_W);
    localparam int CNT_W = DOT_PERIOD_W + 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MARK     = 3'd1,
        ELEM_GAP = 3'd2,
        CHAR_GAP = 3'd3,
        WORD_GAP = 3'd4
    } state_t;

    // Pattern is read MSB-first over len elements; a 1 bit is a dash.
    typedef struct packed {
        logic              known;
        logic [2:0]        len;
        logic [ELEM_W-1:0] pat;
    } code_t;

    function automatic code_t mk(input logic [2:0] len, input logic [4:0] pat);
        code_t r;
        r.known = 1'b1;
        r.len   = len;
        r.pat   = ELEM_W'(pat);
        return r;
    endfunction

    function automatic code_t lookup(input logic [7:0] c);
        code_t      r;
        logic [7:0] u;
        u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        case (u)
            8'h41: r = mk(3'd2, 5'b00001);
            8'h42: r = mk(3'd4, 5'b01000);
            8'h43: r = mk(3'd4, 5'b01010);
            8'h44: r = mk(3'd3, 5'b00100);
            8'h45: r = mk(3'd1, 5'b00000);
            8'h46: r = mk(3'd4, 5'b00010);
            8'h47: r = mk(3'd3, 5'b00110);
            8'h48: r = mk(3'd4, 5'b00000);
            8'h49: r = mk(3'd2, 5'b00000);
            8'h4A: r = mk(3'd4, 5'b00111);
            8'h4B: r = mk(3'd3, 5'b00101);
            8'h4C: r = mk(3'd4, 5'b00100);
            8'h4D: r = mk(3'd2, 5'b00011);
            8'h4E: r = mk(3'd2, 5'b00010);
            8'h4F: r = mk(3'd3, 5'b00111);
            8'h50: r = mk(3'd4, 5'b00110);
            8'h51: r = mk(3'd4, 5'b01101);
            8'h52: r = mk(3'd3, 5'b00010);
            8'h53: r = mk(3'd3, 5'b00000);
            8'h54: r = mk(3'd1, 5'b00001);
            8'h55: r = mk(3'd3, 5'b00001);
            8'h56: r = mk(3'd4, 5'b00001);
            8'h57: r = mk(3'd3, 5'b00011);
            8'h58: r = mk(3'd4, 5'b01001);
            8'h59: r = mk(3'd4, 5'b01011);
            8'h5A: r = mk(3'd4, 5'b01100);
`ifdef MORSE_TX_DIGITS_EN
            8'h30: r = mk(3'd5, 5'b11111);
            8'h31: r = mk(3'd5, 5'b01111);
            8'h32: r = mk(3'd5, 5'b00111);
            8'h33: r = mk(3'd5, 5'b00011);
            8'h34: r = mk(3'd5, 5'b00001);
            8'h35: r = mk(3'd5, 5'b00000);
            8'h36: r = mk(3'd5, 5'b10000);
            8'h37: r = mk(3'd5, 5'b11000);
            8'h38: r = mk(3'd5, 5'b11100);
            8'h39: r = mk(3'd5, 5'b11110);
`endif
            default: begin
                r       = mk(3'd0, 5'b00000);
                r.known = 1'b0;
            end
        endcase
        return r;
    endfunction

    state_t                  state_r, state_n_s;
    logic [CNT_W-1:0]        cnt_r, cnt_n_s;
    logic [DOT_PERIOD_W-1:0] p_r, p_n_s, p_sel_s;
    logic [ELEM_W-1:0]       elem_r, elem_n_s;
    logic [IDX_W-1:0]        idx_r, idx_n_s, idx0_s;
    logic [CNT_W-1:0]        p_ext_s, dot_s, three_s, four_s;
    code_t                   lk_s;
    logic                    morse_r, morse_n_s, ready_r, ready_n_s, busy_r;
    logic                    unknown_r, unknown_n_s, dp_err_r, dp_err_n_s;

    // Phase lengths minus one, from the latched period or the one being accepted.
    always_comb begin
        p_sel_s = (state_r == IDLE) ? bus.dot_period : p_r;
        p_ext_s = {2'b00, p_sel_s};
        dot_s   = p_ext_s - {{(CNT_W-1){1'b0}}, 1'b1};
        three_s = (p_ext_s << 1) + p_ext_s - {{(CNT_W-1){1'b0}}, 1'b1};
        four_s  = (p_ext_s << 2) - {{(CNT_W-1){1'b0}}, 1'b1};
        lk_s    = lookup(bus.tx_char);
        idx0_s  = IDX_W'(lk_s.len - 3'd1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n_s   = state_r;
        cnt_n_s     = cnt_r;
        p_n_s       = p_r;
        elem_n_s    = elem_r;
        idx_n_s     = idx_r;
        morse_n_s   = 1'b0;
        unknown_n_s = 1'b0;
        dp_err_n_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.char_valid) begin
                    if (bus.dot_period == {DOT_PERIOD_W{1'b0}}) begin
                        dp_err_n_s = 1'b1;
                    end else if (bus.tx_char == 8'h20) begin
                        p_n_s     = bus.dot_period;
                        cnt_n_s   = four_s;
                        state_n_s = WORD_GAP;
                    end else if (lk_s.known) begin
                        p_n_s     = bus.dot_period;
                        elem_n_s  = lk_s.pat;
                        idx_n_s   = idx0_s;
                        cnt_n_s   = lk_s.pat[idx0_s] ? three_s : dot_s;
                        morse_n_s = 1'b1;
                        state_n_s = MARK;
                    end else begin
                        unknown_n_s = 1'b1;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            MARK: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    if (idx_r == {IDX_W{1'b0}}) begin
                        cnt_n_s   = three_s;
                        state_n_s = CHAR_GAP;
                    end else begin
                        cnt_n_s   = dot_s;
                        idx_n_s   = idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                        state_n_s = ELEM_GAP;
                    end
                end else begin
                    cnt_n_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    morse_n_s = 1'b1;
                end
            end
            ELEM_GAP: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    cnt_n_s   = elem_r[idx_r] ? three_s : dot_s;
                    morse_n_s = 1'b1;
                    state_n_s = MARK;
                end else begin
                    cnt_n_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_n_s = IDLE;
                end else begin
                    cnt_n_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
        ready_n_s = (state_n_s == IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r     <= {CNT_W{1'b0}};
            p_r       <= {DOT_PERIOD_W{1'b0}};
            elem_r    <= {ELEM_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            morse_r   <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            unknown_r <= 1'b0;
            dp_err_r  <= 1'b0;
        end else begin
            cnt_r     <= cnt_n_s;
            p_r       <= p_n_s;
            elem_r    <= elem_n_s;
            idx_r     <= idx_n_s;
            morse_r   <= morse_n_s;
            ready_r   <= ready_n_s;
            busy_r    <= ~ready_n_s;
            unknown_r <= unknown_n_s;
            dp_err_r  <= dp_err_n_s;
        end
    end

    assign bus.morse            = morse_r;
    assign bus.char_ready       = ready_r;
    assign bus.busy             = busy_r;
    assign bus.unknown          = unknown_r;
    assign bus.dot_period_error = dp_err_r;
endmodule

// File: tb/tb_morse_char_transmitter.sv
// Bench for morse_char_transmitter: a dot/dash string model builds per-cycle expectations,
// one negedge process compares them; MORSE_TX_DIGITS_EN selects the digit expectations.
module tb_morse_char_transmitter;
    localparam int DOT_PERIOD_W = 16;
    localparam logic [4:0] IDLE_VEC = 5'b00100;  // {morse,busy,ready,unknown,dperr}

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic chk_en = 1'b0;
    logic [4:0] exp_q[$];

    morse_char_transmitter_if #(.DOT_PERIOD_W(DOT_PERIOD_W)) bus ();

    morse_char_transmitter #(.DOT_PERIOD_W(DOT_PERIOD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....",
                          "--...", "---..", "----."};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model: append the expected output vector of every cycle after the accept edge.
    task automatic build(input logic [7:0] c, input int p);
        string      s;
        logic [7:0] u;
        bit         known;
        u     = ((c >= 8'h61) && (c <= 8'h7A)) ? c - 8'h20 : c;
        known = 1'b0;
        if (p == 0) begin
            exp_q.push_back(5'b00101);
            return;
        end
        if (c == 8'h20) begin
            repeat (4 * p) exp_q.push_back(5'b01000);
            return;
        end
        if ((u >= 8'h41) && (u <= 8'h5A)) begin
            s = letters[int'(u - 8'h41)];
            known = 1'b1;
        end
`ifdef MORSE_TX_DIGITS_EN
        if ((u >= 8'h30) && (u <= 8'h39)) begin
            s = digits[int'(u - 8'h30)];
            known = 1'b1;
        end
`endif
        if (!known) begin
            exp_q.push_back(5'b00110);
            return;
        end
        for (int i = 0; i < s.len(); i++) begin
            repeat ((s[i] == 8'h2D) ? 3 * p : p) exp_q.push_back(5'b11000);
            repeat ((i == s.len() - 1) ? 3 * p : p) exp_q.push_back(5'b01000);
        end
    endtask

    // Single compare process: every cycle while enabled, DUT outputs vs model.
    always @(negedge clk) begin
        logic [4:0] e;
        cyc++;
        if (chk_en) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = IDLE_VEC;
            check($sformatf("cycle %0d outputs", cyc),
                  {27'd0, bus.morse, bus.busy, bus.char_ready, bus.unknown, bus.dot_period_error},
                  {27'd0, e});
        end
    end

    // Called at posedge+1: wait for the model to drain, offer c for one cycle, queue its wave.
    task automatic send(input logic [7:0] c, input int p);
        int guard = 0;
        while ((exp_q.size() != 0) && (guard < 5000)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain before send", exp_q.size(), 0);
        exp_q.delete();
        bus.tx_char    = c;
        bus.dot_period = DOT_PERIOD_W'(p);
        bus.char_valid = 1'b1;
        @(posedge clk);
        build(c, p);
        #1;
        bus.char_valid = 1'b0;
        bus.dot_period = DOT_PERIOD_W'(p + 7);
    endtask

    logic [7:0] v_char[17] = '{8'h45, 8'h41, 8'h23, 8'h4B, 8'h54, 8'h20, 8'h71, 8'h61, 8'h35,
                               8'h39, 8'h7E, 8'h5A, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7A};
    int         v_p[17]    = '{4, 2, 3, 0, 5, 5, 1, 3, 1, 2, 2, 1, 1, 1, 1, 1, 2};

    initial begin
        logic [15:0] m;
        int          cnt;
        bus.tx_char    = 8'h00;
        bus.char_valid = 1'b0;
        bus.dot_period = DOT_PERIOD_W'(1);
        rst            = 1'b0;

        // Pin the model with hand-computed waveforms.
        build(8'h41, 2);
        m = 16'h0000;
        for (int i = 0; i < exp_q.size() && i < 16; i++) m[15 - i] = exp_q[i][4];
        check("model A length", exp_q.size(), 16);
        check("model A wave", {16'd0, m}, 32'b1100111111000000);
        exp_q.delete();
        build(8'h45, 4);
        cnt = 0;
        foreach (exp_q[i]) if (exp_q[i][4]) cnt++;
        check("model E length", exp_q.size(), 16);
        check("model E marks", cnt, 4);
        exp_q.delete();
        build(8'h20, 5);
        cnt = 0;
        foreach (exp_q[i]) if (exp_q[i] == 5'b01000) cnt++;
        check("model space gap", cnt, 20);
        exp_q.delete();
        build(8'h35, 1);
`ifdef MORSE_TX_DIGITS_EN
        m = 16'h0000;
        for (int i = 0; i < exp_q.size() && i < 12; i++) m[11 - i] = exp_q[i][4];
        check("model 5 length", exp_q.size(), 12);
        check("model 5 wave", {16'd0, m}, 32'b101010101000);
`else
        check("model 5 length", exp_q.size(), 1);
        check("model 5 unknown", {27'd0, exp_q[0]}, 32'b00110);
`endif
        exp_q.delete();

        // Reset state.
        #1 rst = 1'b1;
        #1;
        check("reset ready", bus.char_ready, 1);
        check("reset outputs", {bus.morse, bus.busy, bus.unknown, bus.dot_period_error}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        foreach (v_char[i]) send(v_char[i], v_p[i]);

        // Reset in the middle of the first dash of 'O'.
        send(8'h4F, 2);
        repeat (3) @(posedge clk);
        #1;
        check("O mid dash mark", bus.morse, 1);
        chk_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("abort morse low", bus.morse, 0);
        check("abort ready", bus.char_ready, 1);
        check("abort busy", bus.busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        send(8'h45, 2);

        for (int g = 0; (g < 5000) && (exp_q.size() != 0); g++) @(posedge clk);
        check("final drain", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
